// File: rtl/invaders_pkg.sv
// Shared formation geometry and hit-detect FSM states for the invaders game.
package invaders_pkg;

    localparam int INV_ROWS          = 5;
    localparam int INV_COLS          = 8;
    localparam int INV_ALIEN_W       = 32;
    localparam int INV_ALIEN_H       = 24;
    localparam int INV_SPACING_X     = 48;
    localparam int INV_SPACING_Y     = 40;
    localparam int INV_BULLET_W      = 4;
    localparam int INV_BULLET_H      = 16;
    localparam int INV_SCORE_PER_HIT = 10;

    // Screen coordinates are 12 bit; one extra bit keeps rectangle edge sums from wrapping.
    localparam int COORD_W = 12;
    localparam int ACC_W   = 13;

    typedef enum logic [1:0] {
        HIT_IDLE,
        HIT_SCAN,
        HIT_LOCK
    } hit_state_t;

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned rectangle intersection test (edges touching do not overlap).
module rect_overlap
    import invaders_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic [W-1:0] a_x,
    input  logic [W-1:0] a_y,
    input  logic [W-1:0] a_w,
    input  logic [W-1:0] a_h,
    input  logic [W-1:0] b_x,
    input  logic [W-1:0] b_y,
    input  logic [W-1:0] b_w,
    input  logic [W-1:0] b_h,
    output logic         overlap
);

    // Both axes must intersect; callers size W so the edge sums cannot wrap.
    always_comb begin
        overlap = (a_x < b_x + b_w) && (a_x + a_w > b_x) &&
                  (a_y < b_y + b_h) && (a_y + a_h > b_y);
    end

endmodule

// File: rtl/alien_hit_detect.sv
// Bullet-vs-formation collision: scans one formation cell per cycle, retires the
// bullet on the first live overlapping alien, and owns alive mask, count and score.
module alien_hit_detect
    import invaders_pkg::*;
#(
    parameter int ALIEN_ROWS    = INV_ROWS,
    parameter int ALIEN_COLS    = INV_COLS,
    parameter int ALIEN_WIDTH   = INV_ALIEN_W,
    parameter int ALIEN_HEIGHT  = INV_ALIEN_H,
    parameter int SPACING_X     = INV_SPACING_X,
    parameter int SPACING_Y     = INV_SPACING_Y,
    parameter int BULLET_WIDTH  = INV_BULLET_W,
    parameter int BULLET_HEIGHT = INV_BULLET_H,
    parameter int SCORE_PER_HIT = INV_SCORE_PER_HIT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bullet_active,
    input  logic [11:0]                  xpos_shoot,
    input  logic [11:0]                  bullet_y,
    input  logic [11:0]                  grid_x,
    input  logic [11:0]                  grid_y,
    input  logic                         wave_reset,
    output logic                         bullet_hit,
    output logic [ALIEN_ROWS*ALIEN_COLS-1:0] alive_mask,
    output logic [5:0]                   aliens_left,
    output logic [15:0]                  score,
    output logic [2:0]                   hit_row,
    output logic [2:0]                   hit_col,
    output logic                         all_dead
);

    localparam int N     = ALIEN_ROWS * ALIEN_COLS;
    localparam int IDX_W = $clog2(N);
    localparam logic [15:0] SCORE_INC = 16'(SCORE_PER_HIT);

    hit_state_t           state_q, state_d;
    logic [COORD_W-1:0]   snap_bx, snap_by;
    logic [ACC_W-1:0]     snap_gx, cx, cy;
    logic [2:0]           row_q, col_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 load, step, kill;
    logic                 cell_overlap, cell_alive, last_cell;

    assign cell_alive = alive_mask[idx_q];
    assign last_cell  = (idx_q == IDX_W'(N - 1));
    assign all_dead   = (aliens_left == '0);

    rect_overlap #(.W(ACC_W)) u_overlap (
        .a_x     ({1'b0, snap_bx}),
        .a_y     ({1'b0, snap_by}),
        .a_w     (ACC_W'(BULLET_WIDTH)),
        .a_h     (ACC_W'(BULLET_HEIGHT)),
        .b_x     (cx),
        .b_y     (cy),
        .b_w     (ACC_W'(ALIEN_WIDTH)),
        .b_h     (ACC_W'(ALIEN_HEIGHT)),
        .overlap (cell_overlap)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= HIT_IDLE;
        else     state_q <= state_d;
    end

    // Next state and datapath strobes; wave_reset overrides every state.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        kill    = 1'b0;
        if (wave_reset) begin
            state_d = HIT_IDLE;
        end else begin
            case (state_q)
                HIT_IDLE: begin
                    if (bullet_active) begin
                        load    = 1'b1;
                        state_d = HIT_SCAN;
                    end
                end
                HIT_SCAN: begin
                    if (!bullet_active) begin
                        state_d = HIT_IDLE;
                    end else if (cell_alive && cell_overlap) begin
                        kill    = 1'b1;
                        state_d = HIT_LOCK;
                    end else if (last_cell) begin
                        state_d = HIT_IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
                HIT_LOCK: begin
                    if (!bullet_active) state_d = HIT_IDLE;
                end
                default: state_d = HIT_IDLE;
            endcase
        end
    end

    // Snapshot and cell walk: accumulators step by the pitch instead of multiplying.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_bx <= '0;
            snap_by <= '0;
            snap_gx <= '0;
            cx      <= '0;
            cy      <= '0;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
        end else if (load) begin
            snap_bx <= xpos_shoot;
            snap_by <= bullet_y;
            snap_gx <= {1'b0, grid_x};
            cx      <= {1'b0, grid_x};
            cy      <= {1'b0, grid_y};
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
        end else if (step) begin
            idx_q <= idx_q + 1'b1;
            if (col_q == 3'(ALIEN_COLS - 1)) begin
                col_q <= '0;
                row_q <= row_q + 3'd1;
                cx    <= snap_gx;
                cy    <= cy + ACC_W'(SPACING_Y);
            end else begin
                col_q <= col_q + 3'd1;
                cx    <= cx + ACC_W'(SPACING_X);
            end
        end
    end

    // Kill bookkeeping; a wave reset in the same cycle discards the kill entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bullet_hit  <= 1'b0;
            alive_mask  <= '1;
            aliens_left <= 6'(N);
            score       <= '0;
            hit_row     <= '0;
            hit_col     <= '0;
        end else begin
            bullet_hit <= kill;
            if (wave_reset) begin
                alive_mask  <= '1;
                aliens_left <= 6'(N);
            end else if (kill) begin
                alive_mask[idx_q] <= 1'b0;
                aliens_left       <= aliens_left - 6'd1;
                hit_row           <= row_q;
                hit_col           <= col_q;
                if (score > 16'hFFFF - SCORE_INC) score <= '1;
                else                              score <= score + SCORE_INC;
            end
        end
    end

endmodule

// File: tb/tb_alien_hit_detect.sv
// Self-checking bench for alien_hit_detect: directed table, corner sequences and
// randomized kills checked against a geometric reference model.
module tb_alien_hit_detect;

    localparam int ROWS = 5;
    localparam int COLS = 8;
    localparam int NCELL = ROWS * COLS;
    localparam int AW = 32, AH = 24, SX = 48, SY = 40, BW = 4, BH = 16;
    localparam int PTS = 10;

    logic        clk, rst, bullet_active, wave_reset;
    logic [11:0] xpos_shoot, bullet_y, grid_x, grid_y;
    logic        bullet_hit, all_dead;
    logic [NCELL-1:0] alive_mask;
    logic [5:0]  aliens_left;
    logic [15:0] score;
    logic [2:0]  hit_row, hit_col;

    alien_hit_detect dut (
        .clk           (clk),
        .rst           (rst),
        .bullet_active (bullet_active),
        .xpos_shoot    (xpos_shoot),
        .bullet_y      (bullet_y),
        .grid_x        (grid_x),
        .grid_y        (grid_y),
        .wave_reset    (wave_reset),
        .bullet_hit    (bullet_hit),
        .alive_mask    (alive_mask),
        .aliens_left   (aliens_left),
        .score         (score),
        .hit_row       (hit_row),
        .hit_col       (hit_col),
        .all_dead      (all_dead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [NCELL-1:0] m_mask;
    int m_score, m_left;

    typedef struct {
        string nm;
        int gx, gy, bx, by;
        int exp_idx;   // -1 means no hit expected
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Lowest-index live alien overlapped by the bullet, from plain geometry.
    function automatic int ref_hit(input int gx, gy, bx, by, input logic [NCELL-1:0] mask);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                int x0 = gx + c * SX;
                int y0 = gy + r * SY;
                if (mask[r*COLS+c] && bx < x0 + AW && bx + BW > x0 && by < y0 + AH && by + BH > y0)
                    return r * COLS + c;
            end
        return -1;
    endfunction

    task automatic model_revive();
        m_mask = '1;
        m_left = NCELL;
    endtask

    task automatic model_kill(input int k);
        m_mask[k] = 1'b0;
        m_left--;
        m_score = (m_score + PTS > 65535) ? 65535 : m_score + PTS;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_hit"}, bullet_hit, 0);
        check({nm, "_mask"}, alive_mask, {NCELL{1'b1}});
        check({nm, "_left"}, aliens_left, NCELL);
        check({nm, "_score"}, score, 0);
        check({nm, "_row"}, hit_row, 0);
        check({nm, "_col"}, hit_col, 0);
        check({nm, "_alldead"}, all_dead, 0);
    endtask

    task automatic set_pos(input int gx, gy, bx, by);
        grid_x     = 12'(gx);
        grid_y     = 12'(gy);
        xpos_shoot = 12'(bx);
        bullet_y   = 12'(by);
    endtask

    // Counts negedges after raising the bullet until a hit pulse or the budget runs out.
    task automatic wait_hit(input int budget, output int n, output bit got);
        got = 1'b0;
        n = 0;
        while (!got && n < budget) begin
            @(negedge clk);
            n++;
            if (bullet_hit === 1'b1) got = 1'b1;
        end
    endtask

    task automatic check_kill(input string nm, input int k, input int n);
        check({nm, "_latency"}, n, k + 2);
        model_kill(k);
        check({nm, "_mask"}, alive_mask, m_mask);
        check({nm, "_left"}, aliens_left, m_left);
        check({nm, "_score"}, score, m_score);
        check({nm, "_row"}, hit_row, k / COLS);
        check({nm, "_col"}, hit_col, k % COLS);
        check({nm, "_alldead"}, all_dead, m_left == 0);
    endtask

    // One bullet: raise, expect a kill of exp_idx (or none), then retire it.
    task automatic run_shot(input string nm, input int gx, gy, bx, by, exp_idx);
        int n;
        bit got;
        set_pos(gx, gy, bx, by);
        bullet_active = 1'b1;
        wait_hit(100, n, got);
        if (exp_idx < 0) begin
            check({nm, "_nohit"}, got, 0);
            check({nm, "_mask"}, alive_mask, m_mask);
            check({nm, "_score"}, score, m_score);
        end else begin
            check({nm, "_hit"}, got, 1);
            if (got) begin
                check_kill(nm, exp_idx, n);
                @(negedge clk);
                check({nm, "_pulse1"}, bullet_hit, 0);
            end
        end
        bullet_active = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_wave_reset();
        wave_reset = 1'b1;
        @(negedge clk);
        wave_reset = 1'b0;
        model_revive();
    endtask

    vec_t vecs[9];

    initial begin
        int n, pulses, iter, k, gx, gy, cx0, cy0, bx, by, e;
        bit got;

        vecs[0] = '{"basic",       100,  50, 206,  95, 10};
        vecs[1] = '{"gap",         100,  50, 134,  55, -1};
        vecs[2] = '{"left_edge",   100,  50,  97,  50,  0};
        vecs[3] = '{"left_touch",  100,  50,  96,  50, -1};
        vecs[4] = '{"br_edge",     100,  50, 131,  73,  0};
        vecs[5] = '{"right_touch", 100,  50, 132,  60, -1};
        vecs[6] = '{"top_touch",   100,  50, 110,  34, -1};
        vecs[7] = '{"last_cell",   100,  50, 440, 215, 39};
        vecs[8] = '{"no_wrap",    4000,4000,4095,4095, 18};

        rst = 1'b1;
        bullet_active = 1'b0;
        wave_reset = 1'b0;
        set_pos(0, 0, 0, 0);
        m_score = 0;
        model_revive();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Directed vectors, each against a freshly revived formation.
        foreach (vecs[i]) begin
            pulse_wave_reset();
            run_shot(vecs[i].nm, vecs[i].gx, vecs[i].gy, vecs[i].bx, vecs[i].by, vecs[i].exp_idx);
        end

        // One kill per bullet while it stays active.
        pulse_wave_reset();
        set_pos(100, 50, 206, 95);
        bullet_active = 1'b1;
        wait_hit(100, n, got);
        check("hold_hit", got, 1);
        if (got) check_kill("hold", 10, n);
        pulses = 0;
        repeat (200) begin
            @(negedge clk);
            if (bullet_hit === 1'b1) pulses++;
        end
        check("hold_second_pulse", pulses, 0);
        bullet_active = 1'b0;
        @(negedge clk);
        @(negedge clk);
        run_shot("dead_cell", 100, 50, 206, 95, -1);

        // Scan abort at cell 5 over a live cell 10 position.
        pulse_wave_reset();
        set_pos(100, 50, 206, 95);
        bullet_active = 1'b1;
        repeat (5) @(negedge clk);
        bullet_active = 1'b0;
        wait_hit(60, n, got);
        check("abort_nohit", got, 0);
        check("abort_score", score, m_score);
        check("abort_mask", alive_mask, m_mask);
        run_shot("after_abort", 100, 50, 206, 95, 10);

        // Random kills from a clean reset until the formation is empty.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_score = 0;
        model_revive();
        iter = 0;
        while (m_left > 0 && iter < 300) begin
            iter++;
            gx = $urandom_range(10, 3000);
            gy = $urandom_range(20, 3000);
            if (iter % 5 == 0) begin
                bx = $urandom_range(0, 4095);
                by = $urandom_range(0, 4095);
            end else begin
                do k = $urandom_range(0, NCELL - 1); while (!m_mask[k]);
                cx0 = gx + (k % COLS) * SX;
                cy0 = gy + (k / COLS) * SY;
                bx = cx0 - (BW - 1) + $urandom_range(0, AW + BW - 2);
                by = cy0 - (BH - 1) + $urandom_range(0, AH + BH - 2);
            end
            e = ref_hit(gx, gy, bx, by, m_mask);
            run_shot("rand", gx, gy, bx, by, e);
        end
        check("all_dead", all_dead, 1);
        check("all_dead_left", aliens_left, 0);
        check("full_score", score, 400);
        run_shot("shot_when_dead", 100, 50, 206, 95, -1);

        pulse_wave_reset();
        check("wave_mask", alive_mask, {NCELL{1'b1}});
        check("wave_left", aliens_left, NCELL);
        check("wave_score", score, 400);
        check("wave_alldead", all_dead, 0);

        // Wave reset landing on the kill edge of cell 10 wins.
        set_pos(100, 50, 206, 95);
        bullet_active = 1'b1;
        pulses = 0;
        repeat (11) begin
            @(negedge clk);
            if (bullet_hit === 1'b1) pulses++;
        end
        wave_reset = 1'b1;
        @(negedge clk);
        wave_reset = 1'b0;
        bullet_active = 1'b0;
        check("coinc_early_pulse", pulses, 0);
        check("coinc_hit", bullet_hit, 0);
        check("coinc_score", score, 400);
        check("coinc_mask", alive_mask, {NCELL{1'b1}});
        check("coinc_left", aliens_left, NCELL);
        @(negedge clk);

        // Asynchronous reset while locked.
        set_pos(100, 50, 206, 95);
        bullet_active = 1'b1;
        wait_hit(100, n, got);
        check("lock_hit", got, 1);
        if (got) check_kill("lock", 10, n);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        m_score = 0;
        model_revive();
        @(negedge clk);
        rst = 1'b0;
        wait_hit(100, n, got);
        check("rehit", got, 1);
        if (got) check_kill("rehit", 10, n);
        bullet_active = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
